sb_rx_deframer: RTL and testbench
=================================

# sb_rx_deframer

Sideband receive deframer between the electrical-layer `sbrx` serial line and the logical layer's sideband transaction handling. It recovers UART-framed bytes from `sbrx` at one bit per `sb_clk` cycle. It strips DLE stuffing and delimits DLE/STX … DLE/ETX transactions. It then presents header and payload bytes as a single-cycle-pulse byte stream with start, end and error markers.

## Interface
Parameters:
- `MAX_LEN`, 64: maximum payload bytes per transaction, excluding the header; range 1–255.
- `DLE`, 8'hFE: data-link-escape byte.
- `ETX`, 8'h40: end-of-transaction byte.

Ports:
- `sb_clk`, in, 1: sideband clock. It is the only clock, and `sbrx` is sampled on its rising edge.
- `rst`, in, 1: reset, asynchronous, active-low.
- `sbrx`, in, 1: serial sideband input; idles high.
- `rx_byte`, out, 8: header or payload byte; meaningful only while `rx_valid` is high.
- `rx_valid`, out, 1: one-cycle pulse per delivered byte.
- `rx_sot`, out, 1: high together with `rx_valid` on the header (STX) byte.
- `rx_eot`, out, 1: one-cycle pulse at a good DLE/ETX; never coincides with `rx_valid`.
- `rx_len`, out, $clog2(MAX_LEN+1): payload byte count of the current transaction. It is stable from `rx_eot` until the next `rx_sot`.
- `rx_err`, out, 1: one-cycle error pulse.
- `err_code`, out, 2: 01 = framing, 10 = bad escape, 11 = overflow. Valid while `rx_err` is high and holds its last value otherwise.
- `trans_active`, out, 1: high from `rx_sot` until `rx_eot`, an error abort, or reset.

## Operation
Bit FSM (B_IDLE, B_DATA, B_STOP, B_WAIT_HIGH):
- B_IDLE: `sbrx`=0 is the start bit → go to B_DATA with the bit count at 0.
- B_DATA: shift in 8 bits, LSB first; after the 8th bit → B_STOP.
- B_STOP:
  - `sbrx`=1 → byte complete, hand it to the byte FSM, go to B_IDLE.
  - `sbrx`=0 → framing error (`rx_err`, code 01), discard the byte, go to B_WAIT_HIGH.
- B_WAIT_HIGH: stay until `sbrx`=1, then go to B_IDLE. This stops a stuck-low line from producing repeated bytes.

Byte FSM (Y_IDLE, Y_HDR_DLE, Y_HDR, Y_DATA, Y_ESC):
- Y_IDLE: DLE → Y_HDR_DLE. Any other byte is ignored.
- Y_HDR_DLE:
  - DLE → stay (the byte is treated as a new DLE).
  - ETX → Y_IDLE, no output, no error.
  - Any other byte → it is the header: emit with `rx_valid`=`rx_sot`=1, clear `rx_len` to 0, set `trans_active`, go to Y_DATA.
- Y_DATA:
  - DLE → Y_ESC, no output.
  - Any other byte → emit as payload and increment `rx_len`.
- Y_ESC:
  - DLE → emit 8'hFE as payload (unstuffing), increment `rx_len`, return to Y_DATA.
  - ETX → pulse `rx_eot`, clear `trans_active`, go to Y_IDLE.
  - Any other byte → `rx_err` with code 10, clear `trans_active`, go to Y_IDLE.

Rules and boundary cases:
- Overflow: a payload byte arriving when `rx_len`==MAX_LEN is not emitted. Instead pulse `rx_err` with code 11, clear `trans_active` and go to Y_IDLE. A stuffed FE counts as one byte.
- A framing error while in Y_DATA or Y_ESC also aborts the transaction: clear `trans_active` and go to Y_IDLE. In the other byte states the byte FSM does not change.
- `rx_len` saturates at MAX_LEN and never wraps.
- Reset (asserted at any time, including mid-byte or mid-transaction):
  - Both FSMs return to idle and the shift register clears.
  - All outputs go to 0: `rx_byte`=0, `rx_valid`=0, `rx_sot`=0, `rx_eot`=0, `rx_len`=0, `rx_err`=0, `err_code`=0, `trans_active`=0.
  - A partial byte is lost; no error is reported for it.

## Timing
- Start bit sampled at edge k; data bits at edges k+1 to k+8; stop bit at edge k+9.
- All outputs are registered and update at edge k+9. Pulses are high for exactly the one cycle following edge k+9.
- The earliest next start bit is at edge k+10. Back-to-back bytes therefore arrive every 10 cycles, which the block sustains with no loss.
- Only one of `rx_valid`, `rx_eot` and `rx_err` can be high in any cycle.
- `trans_active` rises at the same edge as `rx_sot`. It falls at the same edge as `rx_eot` or the aborting `rx_err`.
- A DLE byte produces no output in its own slot. The effect of the escape appears at the following byte's k+9 edge.
- Release of `rst`: the first start bit can be sampled at the first `sb_clk` edge after release.

## Test plan
- Reset: assert `rst`=0 during data bit 4 of a byte, then release → all outputs 0 and a following clean frame decodes normally.
- Nominal transaction FE 05 12 FE FE 34 FE 40, back-to-back → `rx_sot` with 05; payload 12, FE, 34; `rx_eot`; `rx_len`=3; `trans_active` high from the 05 cycle through to `rx_eot`.
- Framing error: inside a transaction, send byte 0x22 with stop bit 0, hold `sbrx` low 20 cycles, then high → one `rx_err` with code 01, no `rx_valid`, `trans_active` drops; the next FE 05 frame starts cleanly.
- Bad escape: FE 05 FE 33 → `rx_sot` with 05, then `rx_err` with code 10 at the 33 byte's stop edge, `trans_active`=0.
- Overflow with MAX_LEN=4: FE 05 then 01 02 03 04 05 → four `rx_valid` payload pulses, then `rx_err` with code 11 on 05, `rx_len`=4.
- Idle noise: 12 FE 40 FE FE 07 AA FE 40 → 12 ignored; FE 40 silently dropped; FE FE 07 gives `rx_sot` with 07; then AA as payload, `rx_eot`, `rx_len`=1.

Source files
------------

// File: rtl/sb_rx_deframer.sv
// sb_rx_deframer
// Recovers UART-framed bytes from the sideband serial line (one bit per
// sb_clk), removes DLE stuffing and delimits DLE/STX ... DLE/ETX transactions.
// Ports:
//   sb_clk       - sideband clock; sbrx sampled on its rising edge
//   rst          - asynchronous active-low reset
//   sbrx         - serial input, idles high
//   rx_byte      - delivered header/payload byte (qualified by rx_valid)
//   rx_valid     - one-cycle pulse per delivered byte
//   rx_sot       - marks the header byte (with rx_valid)
//   rx_eot       - one-cycle pulse at a good DLE/ETX
//   rx_len       - payload byte count of the current/last transaction
//   rx_err       - one-cycle error pulse
//   err_code     - 01 framing, 10 bad escape, 11 overflow (holds last value)
//   trans_active - high while a transaction is open
module sb_rx_deframer #(
    parameter int         MAX_LEN = 64,
    parameter logic [7:0] DLE     = 8'hFE,
    parameter logic [7:0] ETX     = 8'h40
) (
    input  logic                         sb_clk,
    input  logic                         rst,
    input  logic                         sbrx,
    output logic [7:0]                   rx_byte,
    output logic                         rx_valid,
    output logic                         rx_sot,
    output logic                         rx_eot,
    output logic [$clog2(MAX_LEN+1)-1:0] rx_len,
    output logic                         rx_err,
    output logic [1:0]                   err_code,
    output logic                         trans_active
);
    localparam int LW = $clog2(MAX_LEN + 1);
    localparam logic [LW-1:0] LEN_MAX = LW'(MAX_LEN);

    typedef enum logic [1:0] {B_IDLE, B_DATA, B_STOP, B_WAIT_HIGH} bit_state_t;
    typedef enum logic [2:0] {Y_IDLE, Y_HDR_DLE, Y_HDR, Y_DATA, Y_ESC} byte_state_t;

    bit_state_t  bstate_r, bnext_s;
    byte_state_t ystate_r, ynext_s;
    logic [2:0]  cnt_r, cnt_s;
    logic [7:0]  sh_r, sh_s;
    logic        byte_done_s, frame_err_s, push_s;

    logic [7:0]    byte_s;
    logic          valid_s, sot_s, eot_s, err_s, act_s;
    logic [1:0]    code_s;
    logic [LW-1:0] len_s;

    // Bit-level state, bit counter and shift register.
    always_ff @(posedge sb_clk or negedge rst) begin
        if (!rst) begin
            bstate_r <= B_IDLE;
            cnt_r    <= 3'd0;
            sh_r     <= 8'h00;
        end else begin
            bstate_r <= bnext_s;
            cnt_r    <= cnt_s;
            sh_r     <= sh_s;
        end
    end

    // Bit FSM: start bit, 8 data bits LSB first, stop bit check.
    always_comb begin
        bnext_s     = bstate_r;
        cnt_s       = cnt_r;
        sh_s        = sh_r;
        byte_done_s = 1'b0;
        frame_err_s = 1'b0;
        case (bstate_r)
            B_IDLE: begin
                if (!sbrx) begin
                    bnext_s = B_DATA;
                    cnt_s   = 3'd0;
                end else begin
                    bnext_s = B_IDLE;
                end
            end
            B_DATA: begin
                sh_s  = {sbrx, sh_r[7:1]};
                cnt_s = cnt_r + 3'd1;
                if (cnt_r == 3'd7) begin
                    bnext_s = B_STOP;
                end else begin
                    bnext_s = B_DATA;
                end
            end
            B_STOP: begin
                if (sbrx) begin
                    byte_done_s = 1'b1;
                    bnext_s     = B_IDLE;
                end else begin
                    frame_err_s = 1'b1;
                    bnext_s     = B_WAIT_HIGH;
                end
            end
            B_WAIT_HIGH: begin
                // A stuck-low line must not be read as a stream of zero bytes.
                if (sbrx) begin
                    bnext_s = B_IDLE;
                end else begin
                    bnext_s = B_WAIT_HIGH;
                end
            end
            default: bnext_s = B_IDLE;
        endcase
    end

    // Byte-level state and all registered outputs.
    always_ff @(posedge sb_clk or negedge rst) begin
        if (!rst) begin
            ystate_r     <= Y_IDLE;
            rx_byte      <= 8'h00;
            rx_valid     <= 1'b0;
            rx_sot       <= 1'b0;
            rx_eot       <= 1'b0;
            rx_len       <= '0;
            rx_err       <= 1'b0;
            err_code     <= 2'b00;
            trans_active <= 1'b0;
        end else begin
            ystate_r     <= ynext_s;
            rx_byte      <= byte_s;
            rx_valid     <= valid_s;
            rx_sot       <= sot_s;
            rx_eot       <= eot_s;
            rx_len       <= len_s;
            rx_err       <= err_s;
            err_code     <= code_s;
            trans_active <= act_s;
        end
    end

    // Byte FSM: escape handling, transaction delimiting, error aborts.
    always_comb begin
        ynext_s = ystate_r;
        byte_s  = rx_byte;
        valid_s = 1'b0;
        sot_s   = 1'b0;
        eot_s   = 1'b0;
        err_s   = 1'b0;
        code_s  = err_code;
        len_s   = rx_len;
        act_s   = trans_active;
        push_s  = 1'b0;
        if (frame_err_s) begin
            err_s  = 1'b1;
            code_s = 2'b01;
            if ((ystate_r == Y_DATA) || (ystate_r == Y_ESC)) begin
                ynext_s = Y_IDLE;
                act_s   = 1'b0;
            end else begin
                ynext_s = ystate_r;
            end
        end else if (byte_done_s) begin
            case (ystate_r)
                Y_IDLE: begin
                    if (sh_r == DLE) begin
                        ynext_s = Y_HDR_DLE;
                    end else begin
                        ynext_s = Y_IDLE;
                    end
                end
                Y_HDR_DLE: begin
                    if (sh_r == DLE) begin
                        ynext_s = Y_HDR_DLE;
                    end else if (sh_r == ETX) begin
                        ynext_s = Y_IDLE;
                    end else begin
                        byte_s  = sh_r;
                        valid_s = 1'b1;
                        sot_s   = 1'b1;
                        len_s   = '0;
                        act_s   = 1'b1;
                        ynext_s = Y_DATA;
                    end
                end
                Y_DATA: begin
                    if (sh_r == DLE) begin
                        ynext_s = Y_ESC;
                    end else begin
                        push_s = 1'b1;
                    end
                end
                Y_ESC: begin
                    if (sh_r == DLE) begin
                        push_s  = 1'b1;
                        ynext_s = Y_DATA;
                    end else if (sh_r == ETX) begin
                        eot_s   = 1'b1;
                        act_s   = 1'b0;
                        ynext_s = Y_IDLE;
                    end else begin
                        err_s   = 1'b1;
                        code_s  = 2'b10;
                        act_s   = 1'b0;
                        ynext_s = Y_IDLE;
                    end
                end
                // Y_HDR is a reserved encoding that is never entered.
                default: ynext_s = Y_IDLE;
            endcase
            // Payload delivery shared by plain and unstuffed bytes; a full
            // transaction aborts instead of wrapping the count.
            if (push_s) begin
                if (rx_len == LEN_MAX) begin
                    err_s   = 1'b1;
                    code_s  = 2'b11;
                    act_s   = 1'b0;
                    ynext_s = Y_IDLE;
                end else begin
                    byte_s  = sh_r;
                    valid_s = 1'b1;
                    len_s   = rx_len + {{(LW-1){1'b0}}, 1'b1};
                end
            end else begin
                len_s = len_s;
            end
        end else begin
            ynext_s = ystate_r;
        end
    end
endmodule

// File: tb/tb_sb_rx_deframer.sv
module tb_sb_rx_deframer;
    logic       sb_clk = 1'b0;
    logic       rst;
    logic       sbrx;
    logic [7:0] rx_byte;
    logic       rx_valid, rx_sot, rx_eot, rx_err, trans_active;
    logic [2:0] rx_len;
    logic [1:0] err_code;

    int tests = 0;
    int fails = 0;
    int pulse_cnt = 0;

    sb_rx_deframer #(.MAX_LEN(4), .DLE(8'hFE), .ETX(8'h40)) dut (
        .sb_clk(sb_clk), .rst(rst), .sbrx(sbrx),
        .rx_byte(rx_byte), .rx_valid(rx_valid), .rx_sot(rx_sot),
        .rx_eot(rx_eot), .rx_len(rx_len), .rx_err(rx_err),
        .err_code(err_code), .trans_active(trans_active)
    );

    always #5 sb_clk = ~sb_clk;

    typedef struct {
        logic [7:0] data;
        logic       stop;
        int         hold;
        logic       v, sot, eot, err;
        logic [1:0] code;
        logic [7:0] b;
        logic [2:0] len;
        logic       act;
    } vec_t;

    vec_t vq[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drives start, 8 data bits LSB first and the stop bit on falling edges.
    task automatic send_byte(input logic [7:0] d, input logic stop);
        @(negedge sb_clk) sbrx = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge sb_clk) sbrx = d[i];
        end
        @(negedge sb_clk) sbrx = stop;
    endtask

    task automatic check_all_zero(input string name);
        check(name, {rx_byte, rx_valid, rx_sot, rx_eot, 5'(rx_len), rx_err, err_code, trans_active}, 32'd0);
    endtask

    // Pulse monitor: exclusivity, single-cycle width, sot qualified by valid.
    logic pv = 1'b0, pe = 1'b0, pr = 1'b0;
    always @(posedge sb_clk) begin
        #1;
        if (rst) begin
            if (rx_valid | rx_eot | rx_err) begin
                pulse_cnt++;
                check("pulse_exclusive", $countones({rx_valid, rx_eot, rx_err}), 1);
            end
            if (rx_sot) check("sot_with_valid", rx_valid, 1'b1);
            if (pv | pe | pr) check("pulse_width", {rx_valid, rx_eot, rx_err}, 3'b000);
            pv = rx_valid; pe = rx_eot; pr = rx_err;
        end else begin
            pv = 1'b0; pe = 1'b0; pr = 1'b0;
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        //         data   stp hold v     sot   eot   err   code   byte   len   act
        // nominal FE 05 12 FE FE 34 FE 40
        vq.push_back('{8'hFE,1'b1,0,1'b0,1'b0,1'b0,1'b0,2'd0,8'h00,3'd0,1'b0});
        vq.push_back('{8'h05,1'b1,0,1'b1,1'b1,1'b0,1'b0,2'd0,8'h05,3'd0,1'b1});
        vq.push_back('{8'h12,1'b1,0,1'b1,1'b0,1'b0,1'b0,2'd0,8'h12,3'd1,1'b1});
        vq.push_back('{8'hFE,1'b1,0,1'b0,1'b0,1'b0,1'b0,2'd0,8'h00,3'd1,1'b1});
        vq.push_back('{8'hFE,1'b1,0,1'b1,1'b0,1'b0,1'b0,2'd0,8'hFE,3'd2,1'b1});
        vq.push_back('{8'h34,1'b1,0,1'b1,1'b0,1'b0,1'b0,2'd0,8'h34,3'd3,1'b1});
        vq.push_back('{8'hFE,1'b1,0,1'b0,1'b0,1'b0,1'b0,2'd0,8'h00,3'd3,1'b1});
        vq.push_back('{8'h40,1'b1,0,1'b0,1'b0,1'b1,1'b0,2'd0,8'h00,3'd3,1'b0});
        // framing error mid-transaction, line held low, then clean restart
        vq.push_back('{8'hFE,1'b1,0,1'b0,1'b0,1'b0,1'b0,2'd0,8'h00,3'd3,1'b0});
        vq.push_back('{8'h05,1'b1,0,1'b1,1'b1,1'b0,1'b0,2'd0,8'h05,3'd0,1'b1});
        vq.push_back('{8'h22,1'b0,20,1'b0,1'b0,1'b0,1'b1,2'd1,8'h00,3'd0,1'b0});
        vq.push_back('{8'hFE,1'b1,0,1'b0,1'b0,1'b0,1'b0,2'd0,8'h00,3'd0,1'b0});
        vq.push_back('{8'h05,1'b1,0,1'b1,1'b1,1'b0,1'b0,2'd0,8'h05,3'd0,1'b1});
        // bad escape
        vq.push_back('{8'hFE,1'b1,0,1'b0,1'b0,1'b0,1'b0,2'd0,8'h00,3'd0,1'b1});
        vq.push_back('{8'h33,1'b1,0,1'b0,1'b0,1'b0,1'b1,2'd2,8'h00,3'd0,1'b0});
        // overflow with plain byte
        vq.push_back('{8'hFE,1'b1,0,1'b0,1'b0,1'b0,1'b0,2'd0,8'h00,3'd0,1'b0});
        vq.push_back('{8'h05,1'b1,0,1'b1,1'b1,1'b0,1'b0,2'd0,8'h05,3'd0,1'b1});
        vq.push_back('{8'h01,1'b1,0,1'b1,1'b0,1'b0,1'b0,2'd0,8'h01,3'd1,1'b1});
        vq.push_back('{8'h02,1'b1,0,1'b1,1'b0,1'b0,1'b0,2'd0,8'h02,3'd2,1'b1});
        vq.push_back('{8'h03,1'b1,0,1'b1,1'b0,1'b0,1'b0,2'd0,8'h03,3'd3,1'b1});
        vq.push_back('{8'h04,1'b1,0,1'b1,1'b0,1'b0,1'b0,2'd0,8'h04,3'd4,1'b1});
        vq.push_back('{8'h05,1'b1,0,1'b0,1'b0,1'b0,1'b1,2'd3,8'h00,3'd4,1'b0});
        // overflow with a stuffed FE
        vq.push_back('{8'hFE,1'b1,0,1'b0,1'b0,1'b0,1'b0,2'd0,8'h00,3'd4,1'b0});
        vq.push_back('{8'h05,1'b1,0,1'b1,1'b1,1'b0,1'b0,2'd0,8'h05,3'd0,1'b1});
        vq.push_back('{8'h01,1'b1,0,1'b1,1'b0,1'b0,1'b0,2'd0,8'h01,3'd1,1'b1});
        vq.push_back('{8'h02,1'b1,0,1'b1,1'b0,1'b0,1'b0,2'd0,8'h02,3'd2,1'b1});
        vq.push_back('{8'h03,1'b1,0,1'b1,1'b0,1'b0,1'b0,2'd0,8'h03,3'd3,1'b1});
        vq.push_back('{8'h04,1'b1,0,1'b1,1'b0,1'b0,1'b0,2'd0,8'h04,3'd4,1'b1});
        vq.push_back('{8'hFE,1'b1,0,1'b0,1'b0,1'b0,1'b0,2'd0,8'h00,3'd4,1'b1});
        vq.push_back('{8'hFE,1'b1,0,1'b0,1'b0,1'b0,1'b1,2'd3,8'h00,3'd4,1'b0});
        // idle noise 12 FE 40 FE FE 07 AA FE 40
        vq.push_back('{8'h12,1'b1,0,1'b0,1'b0,1'b0,1'b0,2'd0,8'h00,3'd4,1'b0});
        vq.push_back('{8'hFE,1'b1,0,1'b0,1'b0,1'b0,1'b0,2'd0,8'h00,3'd4,1'b0});
        vq.push_back('{8'h40,1'b1,0,1'b0,1'b0,1'b0,1'b0,2'd0,8'h00,3'd4,1'b0});
        vq.push_back('{8'hFE,1'b1,0,1'b0,1'b0,1'b0,1'b0,2'd0,8'h00,3'd4,1'b0});
        vq.push_back('{8'hFE,1'b1,0,1'b0,1'b0,1'b0,1'b0,2'd0,8'h00,3'd4,1'b0});
        vq.push_back('{8'h07,1'b1,0,1'b1,1'b1,1'b0,1'b0,2'd0,8'h07,3'd0,1'b1});
        vq.push_back('{8'hAA,1'b1,0,1'b1,1'b0,1'b0,1'b0,2'd0,8'hAA,3'd1,1'b1});
        vq.push_back('{8'hFE,1'b1,0,1'b0,1'b0,1'b0,1'b0,2'd0,8'h00,3'd1,1'b1});
        vq.push_back('{8'h40,1'b1,0,1'b0,1'b0,1'b1,1'b0,2'd0,8'h00,3'd1,1'b0});

        // Power-on reset.
        sbrx = 1'b1;
        rst  = 1'b0;
        repeat (3) @(negedge sb_clk);
        check_all_zero("reset_state");
        rst = 1'b1;

        // Open a transaction, then reset during data bit 4 of the next byte.
        send_byte(8'hFE, 1'b1);
        send_byte(8'h05, 1'b1);
        @(posedge sb_clk); #1;
        check("pre_reset_sot", {rx_valid, rx_sot, rx_byte, trans_active}, {1'b1, 1'b1, 8'h05, 1'b1});
        @(negedge sb_clk) sbrx = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge sb_clk) sbrx = 1'b1;
        end
        @(posedge sb_clk); #2;
        rst  = 1'b0;
        sbrx = 1'b1;
        #1;
        check_all_zero("midbyte_reset");
        repeat (2) @(negedge sb_clk);
        rst = 1'b1;

        // Table-driven byte stream.
        for (int i = 0; i < vq.size(); i++) begin
            send_byte(vq[i].data, vq[i].stop);
            @(posedge sb_clk); #1;
            check($sformatf("vec%0d_flags", i),
                  {rx_valid, rx_sot, rx_eot, rx_err, rx_len, trans_active},
                  {vq[i].v, vq[i].sot, vq[i].eot, vq[i].err, vq[i].len, vq[i].act});
            if (vq[i].v) check($sformatf("vec%0d_byte", i), rx_byte, vq[i].b);
            if (vq[i].err) check($sformatf("vec%0d_code", i), err_code, vq[i].code);
            if (vq[i].hold > 0) begin
                @(negedge sb_clk);
                begin
                    int pc0;
                    pc0 = pulse_cnt;
                    repeat (vq[i].hold - 1) @(negedge sb_clk);
                    check("stuck_low_code_held", err_code, 2'd1);
                    sbrx = 1'b1;
                    @(negedge sb_clk);
                    check("stuck_low_no_pulses", pulse_cnt, pc0);
                end
            end
        end

        // rx_len stays stable after rx_eot while the line idles.
        repeat (15) @(negedge sb_clk);
        check("len_hold_after_eot", {rx_len, trans_active}, {3'd1, 1'b0});

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
